ins_fetch: RTL and testbench
============================

# ins_fetch

Instruction fetch stage for the RV32I core, upstream of the decoder and execute units. Holds the architectural fetch PC, issues one word request at a time to instruction memory, and buffers the returned instruction with its PC until the decoder accepts it. Consumes the PC-redirect pulse (`reg_pc_w_op`/`reg_pc_w_val`) produced by the jump/branch execute units and discards any wrong-path fetch in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded at reset.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `reg_pc_w_op`  in  1  redirect request from execute; one-cycle pulse.
- `reg_pc_w_val`  in  32  redirect target.
- `mem_req`  out  1  fetch request valid.
- `mem_addr`  out  32  word address (bits[1:0] always 0).
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid; arrives at least 1 cycle after grant.
- `mem_rdata`  in  32  instruction word.
- `ins_valid`  out  1  `ins_data`/`ins_pc` valid for decoder.
- `ins_data`  out  32  fetched instruction.
- `ins_pc`  out  32  PC of `ins_data`.
- `ins_ready`  in  1  decoder accepts instruction.
- `ins_misalign`  out  1  misaligned redirect flag (see Configuration).

## Operation
- States: FETCH (drive `mem_req`), WAIT (granted, awaiting `mem_rvalid`), HOLD (`ins_valid`=1, awaiting `ins_ready`).
- `mem_addr` = `pc` combinationally; `mem_req` = 1 only in FETCH.
- FETCH: on `mem_gnt` → WAIT, latch `pc` into `req_pc`.
- WAIT: on `mem_rvalid` → HOLD, register `ins_data`=`mem_rdata`, `ins_pc`=`req_pc`.
- HOLD: on `ins_ready` → FETCH, `pc`=`ins_pc`+4 (mod 2^32, wraps silently).
- At most one outstanding request; `mem_gnt` outside FETCH is ignored.
- Redirect (`reg_pc_w_op`=1), priority over all other transitions; `pc`=target:
  - FETCH, no grant: stay FETCH; `mem_addr` shows new target next cycle.
  - FETCH with grant same cycle: → WAIT with `kill`=1.
  - WAIT: set `kill`; on `mem_rvalid` with `kill` (including `mem_rvalid` in the redirect cycle itself) drop data, clear `kill`, → FETCH.
  - HOLD: drop instruction (even if `ins_ready`=1 that cycle; no +4 applied), → FETCH.
- `ins_valid` never asserted for killed data.

## Timing
- Reset values: state FETCH, `pc`=`RESET_PC`, `kill`=0, `ins_valid`=0, `ins_data`=0, `ins_pc`=0, `ins_misalign`=0; `mem_req`=1 while in reset (memory must ignore until `rst_n` high).
- Best-case latency: grant in cycle N, `mem_rvalid` N+1, `ins_valid` N+2. Throughput: one instruction per 3 cycles minimum.
- `ins_data`/`ins_pc` stable while `ins_valid`=1 and not accepted.
- Redirect effective on next edge; first new-path `mem_req` with target in cycle after redirect.
- Reset mid-transaction: all state cleared immediately; a late `mem_rvalid` after reset release in FETCH is ignored.

## Configuration
- `INS_FETCH_MISALIGN_TRAP_EN` defined: redirect target with bits[1:0]≠0 pulses `ins_misalign` for 1 cycle, state → FETCH with `pc` unchanged from pre-redirect sequence point? No: `pc` is frozen at target&~3 and `mem_req` held 0 (state HALT) until next aligned redirect or reset.
- Undefined: `ins_misalign` tied 0; targets forced to `{val[31:2],2'b00}`, fetch continues normally; no HALT state.

## Structure
- Shared package: state encoding (FETCH/WAIT/HOLD/HALT), `INS_WIDTH`=32, `PC_STEP`=4, RV32I opcode constants.
- Single module; no sub-module required. PC incrementer is inline.

## Test plan
- Reset release, `RESET_PC`=0x100, grant immediate, rdata 0x00000013 → `ins_valid` with `ins_pc`=0x100, `ins_data`=0x13 at cycle N+2; next `mem_addr`=0x104 after `ins_ready`.
- `ins_ready` held low 5 cycles → outputs stable, no `mem_req`; then accepted → FETCH at pc+4.
- Redirect to 0x200 in WAIT, rvalid 2 cycles later with 0xDEADBEEF → data dropped, next request `mem_addr`=0x200, no `ins_valid` for dropped word.
- Redirect to 0x300 in HOLD same cycle as `ins_ready` → instruction dropped, `mem_addr`=0x300 next cycle.
- `pc`=0xFFFFFFFC accepted → `mem_addr` wraps to 0x0.
- Redirect to 0x202: with macro → `ins_misalign` pulse, `mem_req`=0 until redirect to 0x400; without → `mem_addr`=0x200.

Source files
------------

// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the RV32I instruction fetch stage: fetch FSM state
// encoding, datapath widths, PC stepping and base opcode values.
package ins_fetch_pkg;

    localparam int unsigned INS_WIDTH = 32;
    localparam int unsigned PC_STEP   = 4;

    // Low PC bits that must be zero for a word-aligned fetch address
    localparam logic [INS_WIDTH-1:0] PC_ALIGN_MASK = 32'h0000_0003;

    // HALT is only reachable when the misaligned-redirect trap is built in
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_e;

    // RV32I base opcode field (ins[6:0])
    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b000_0011,
        OPC_MISC_MEM = 7'b000_1111,
        OPC_OP_IMM   = 7'b001_0011,
        OPC_AUIPC    = 7'b001_0111,
        OPC_STORE    = 7'b010_0011,
        OPC_OP       = 7'b011_0011,
        OPC_LUI      = 7'b011_0111,
        OPC_BRANCH   = 7'b110_0011,
        OPC_JALR     = 7'b110_0111,
        OPC_JAL      = 7'b110_1111,
        OPC_SYSTEM   = 7'b111_0011
    } opcode_e;

endpackage

// File: rtl/ins_fetch.sv
// Instruction fetch stage. Keeps the fetch PC, issues one word request at a
// time, buffers the returned word with its PC for the decoder, and applies
// redirects from execute while discarding wrong-path data still in flight.
//
// Build option: INS_FETCH_MISALIGN_TRAP_EN -- a redirect to a non word-aligned
// target pulses ins_misalign and parks the fetcher (no requests) until an
// aligned redirect or reset. Without it, targets are silently word-aligned.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reg_pc_w_op, reg_pc_w_val   redirect pulse and target from execute
//   mem_req, mem_addr           fetch request and word address (from state/pc)
//   mem_gnt                     request accepted
//   mem_rvalid, mem_rdata       returned instruction word
//   ins_valid, ins_data, ins_pc buffered instruction for the decoder
//   ins_ready                   decoder accepts the buffered instruction
//   ins_misalign                one-cycle misaligned redirect flag
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter logic [INS_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reg_pc_w_op,
    input  logic [INS_WIDTH-1:0] reg_pc_w_val,
    output logic                 mem_req,
    output logic [INS_WIDTH-1:0] mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [INS_WIDTH-1:0] mem_rdata,
    output logic                 ins_valid,
    output logic [INS_WIDTH-1:0] ins_data,
    output logic [INS_WIDTH-1:0] ins_pc,
    input  logic                 ins_ready,
    output logic                 ins_misalign
);

    state_e                 state_q, state_d;
    logic [INS_WIDTH-1:0]   pc_q, pc_d;
    logic [INS_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic                   kill_q, kill_d;
    logic                   ins_valid_d;
    logic [INS_WIDTH-1:0]   ins_data_d, ins_pc_d;
    logic                   misalign_d;
    logic [INS_WIDTH-1:0]   redir_tgt;
    logic                   redir_bad;

    // Request address and valid come straight from the registered state/pc
    assign mem_addr = pc_q;
    assign mem_req  = (state_q == FETCH);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
            ins_valid    <= 1'b0;
            ins_data     <= '0;
            ins_pc       <= '0;
            ins_misalign <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            ins_valid    <= ins_valid_d;
            ins_data     <= ins_data_d;
            ins_pc       <= ins_pc_d;
            ins_misalign <= misalign_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        kill_d      = kill_q;
        ins_valid_d = ins_valid;
        ins_data_d  = ins_data;
        ins_pc_d    = ins_pc;
        misalign_d  = 1'b0;

        redir_tgt = reg_pc_w_val & ~PC_ALIGN_MASK;
`ifdef INS_FETCH_MISALIGN_TRAP_EN
        redir_bad = reg_pc_w_op && ((reg_pc_w_val & PC_ALIGN_MASK) != '0);
`else
        redir_bad = 1'b0;
`endif

        case (state_q)
            FETCH: begin
                if (reg_pc_w_op) begin
                    pc_d = redir_tgt;
                    // A request granted alongside the redirect is wrong-path
                    if (mem_gnt) begin
                        state_d = WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (mem_gnt) begin
                    state_d  = WAIT;
                    req_pc_d = pc_q;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (kill_q || reg_pc_w_op) begin
                        state_d = FETCH;
                        kill_d  = 1'b0;
                    end else begin
                        state_d     = HOLD;
                        ins_valid_d = 1'b1;
                        ins_data_d  = mem_rdata;
                        ins_pc_d    = req_pc_q;
                    end
                end
                if (reg_pc_w_op) begin
                    pc_d = redir_tgt;
                    if (!mem_rvalid) begin
                        kill_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (reg_pc_w_op) begin
                    pc_d        = redir_tgt;
                    state_d     = FETCH;
                    ins_valid_d = 1'b0;
                end else if (ins_ready) begin
                    pc_d        = ins_pc + INS_WIDTH'(PC_STEP);
                    state_d     = FETCH;
                    ins_valid_d = 1'b0;
                end
            end
            HALT: begin
                // Drain a killed response that was outstanding when we parked
                if (mem_rvalid) begin
                    kill_d = 1'b0;
                end
                if (reg_pc_w_op) begin
                    pc_d    = redir_tgt;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Misaligned redirect parks the fetcher regardless of current state
        if (redir_bad) begin
            misalign_d  = 1'b1;
            state_d     = HALT;
            ins_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: a vector table of per-cycle inputs and the
// outputs expected after the following clock edge, plus short hand-written
// sequences for the misaligned redirect and mid-transaction reset.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_pc_w_op;
    logic [31:0] reg_pc_w_val;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic        ins_misalign;

    int checks = 0;
    int errors = 0;

    ins_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_pc_w_op  (reg_pc_w_op),
        .reg_pc_w_val (reg_pc_w_val),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .ins_valid    (ins_valid),
        .ins_data     (ins_data),
        .ins_pc       (ins_pc),
        .ins_ready    (ins_ready),
        .ins_misalign (ins_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        op;
        logic [31:0] val;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_data;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic gnt, logic rv, logic [31:0] rdata, logic rdy,
                                logic op, logic [31:0] val, logic e_req,
                                logic [31:0] e_addr, logic e_valid,
                                logic [31:0] e_data, logic [31:0] e_pc);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.op = op; v.val = val;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_data = e_data; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic rdy, input logic op, input logic [31:0] val);
        mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rdata;
        ins_ready = rdy; reg_pc_w_op = op; reg_pc_w_val = val;
    endtask

    initial begin
        // gnt rv rdata rdy op val | req addr valid data pc
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          0,32'h100,0,32'h0,32'h0));        // grant 0x100
        vecs.push_back(mk(0,1,32'h13,0,0,32'h0,         0,32'h100,1,32'h13,32'h100));     // N+2 valid
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,0,32'h0,0,0,32'h0,      0,32'h100,1,32'h13,32'h100));     // stall, gnt ignored
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,          1,32'h104,0,32'h0,32'h0));        // accept -> +4
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h104,0,32'h0,32'h0));        // no grant
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          0,32'h104,0,32'h0,32'h0));        // grant
        vecs.push_back(mk(0,0,32'h0,0,1,32'h200,        0,32'h200,0,32'h0,32'h0));        // redirect in WAIT
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          0,32'h200,0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'hDEADBEEF,0,0,32'h0,   1,32'h200,0,32'h0,32'h0));        // killed data dropped
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          0,32'h200,0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h00A00093,0,0,32'h0,   0,32'h200,1,32'h00A00093,32'h200));
        vecs.push_back(mk(0,0,32'h0,1,1,32'h300,        1,32'h300,0,32'h0,32'h0));        // redirect beats ready
        vecs.push_back(mk(0,0,32'h0,0,1,32'h400,        1,32'h400,0,32'h0,32'h0));        // redirect in FETCH
        vecs.push_back(mk(1,0,32'h0,0,1,32'h500,        0,32'h500,0,32'h0,32'h0));        // redirect + grant
        vecs.push_back(mk(0,1,32'h11111111,0,0,32'h0,   1,32'h500,0,32'h0,32'h0));        // killed
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          0,32'h500,0,32'h0,32'h0));
        vecs.push_back(mk(1,1,32'h22222222,0,0,32'h0,   0,32'h500,1,32'h22222222,32'h500));
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          0,32'h500,1,32'h22222222,32'h500));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,          1,32'h504,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,1,32'hFFFFFFFC,   1,32'hFFFFFFFC,0,32'h0,32'h0));
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          0,32'hFFFFFFFC,0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h33333333,0,0,32'h0,   0,32'hFFFFFFFC,1,32'h33333333,32'hFFFFFFFC));
        vecs.push_back(mk(0,0,32'h0,1,0,32'h0,          1,32'h0,0,32'h0,32'h0));          // wrap to 0
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,          0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h44444444,0,1,32'h600, 1,32'h600,0,32'h0,32'h0));        // redirect with rvalid

        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        cycle();
        cycle();
        chk("rst_mem_req",   32'(mem_req),      32'h1);
        chk("rst_mem_addr",  mem_addr,          32'h100);
        chk("rst_ins_valid", 32'(ins_valid),    32'h0);
        chk("rst_ins_data",  ins_data,          32'h0);
        chk("rst_ins_pc",    ins_pc,            32'h0);
        chk("rst_misalign",  32'(ins_misalign), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy, vecs[i].op, vecs[i].val);
            cycle();
            chk($sformatf("v%0d_req", i),      32'(mem_req),      32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i),     mem_addr,          vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i),    32'(ins_valid),    32'(vecs[i].e_valid));
            chk($sformatf("v%0d_misalign", i), 32'(ins_misalign), 32'h0);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_data", i), ins_data, vecs[i].e_data);
                chk($sformatf("v%0d_pc", i),   ins_pc,   vecs[i].e_pc);
            end
        end

        // Misaligned redirect to 0x202
        drive(0, 0, 32'h0, 0, 1, 32'h202);
        cycle();
`ifdef INS_FETCH_MISALIGN_TRAP_EN
        chk("mis_pulse", 32'(ins_misalign), 32'h1);
        chk("mis_req",   32'(mem_req),      32'h0);
        chk("mis_addr",  mem_addr,          32'h200);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("halt%0d_req", i),      32'(mem_req),      32'h0);
            chk($sformatf("halt%0d_misalign", i), 32'(ins_misalign), 32'h0);
        end
        drive(0, 0, 32'h0, 0, 1, 32'h400);
        cycle();
        chk("unhalt_req",      32'(mem_req),      32'h1);
        chk("unhalt_addr",     mem_addr,          32'h400);
        chk("unhalt_misalign", 32'(ins_misalign), 32'h0);
`else
        chk("mis_pulse", 32'(ins_misalign), 32'h0);
        chk("mis_req",   32'(mem_req),      32'h1);
        chk("mis_addr",  mem_addr,          32'h200);
`endif

        // Reset while an instruction is held, then a stray rvalid in FETCH
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        cycle();
        drive(0, 1, 32'h55, 0, 0, 32'h0);
        cycle();
        chk("pre_rst_valid", 32'(ins_valid), 32'h1);
        chk("pre_rst_data",  ins_data,       32'h55);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ins_valid), 32'h0);
        chk("arst_req",   32'(mem_req),   32'h1);
        chk("arst_addr",  mem_addr,       32'h100);
        chk("arst_data",  ins_data,       32'h0);
        chk("arst_pc",    ins_pc,         32'h0);
        cycle();
        rst_n = 1'b1;
        drive(0, 1, 32'h66, 0, 0, 32'h0);
        cycle();
        chk("late_rv_valid", 32'(ins_valid), 32'h0);
        chk("late_rv_req",   32'(mem_req),   32'h1);
        chk("late_rv_addr",  mem_addr,       32'h100);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        cycle();
        chk("late_rv_valid2", 32'(ins_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
